// File: rtl/load_store_unit.sv
// load_store_unit
// Initiator side of the data-memory port. Takes one CPU load/store request
// at a time and sequences a word-addressed memory whose read data arrives
// one cycle after the read strobe. Byte and half-word stores use a
// read-modify-write of the containing word. Byte and half-word loads pick
// out the addressed lane and sign- or zero-extend it. Misaligned, illegal-size
// and out-of-range requests are answered with an error and never reach memory.

module load_store_unit #(
    parameter int DEPTH = 1024
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,

    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,

    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

    localparam logic [1:0]  SIZE_BYTE   = 2'b00;
    localparam logic [1:0]  SIZE_HALF   = 2'b01;
    localparam logic [1:0]  SIZE_WORD   = 2'b10;
    localparam logic [1:0]  SIZE_ILLEGAL = 2'b11;
    localparam logic [31:0] DEPTH_WORDS = 32'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RD_WAIT,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      state;

    // Request fields kept for the life of one transaction. Only the parts
    // needed after acceptance are held: the byte lane, the size, the
    // extension mode and the low half of the store data for merging.
    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [1:0]  lat_lane;
    logic [15:0] lat_wdata;

    logic        ready_reg;
    logic        rd_strobe;
    logic        wr_strobe;

    logic        req_bad;
    logic        req_accept;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    assign req_accept = req_valid & ready_reg;
    assign req_ready  = ready_reg;

    // Strobes are cut off for the whole reset-high cycle so an abort can
    // never leak a read or a partial write into memory.
    assign mem_read   = rd_strobe & ~reset;
    assign mem_write  = wr_strobe & ~reset;

    // Decide at acceptance whether the request may touch memory at all.
    always_comb begin
        req_bad = 1'b0;
        if (req_size == SIZE_ILLEGAL) begin
            req_bad = 1'b1;
        end
        if ((req_size == SIZE_HALF) && req_addr[0]) begin
            req_bad = 1'b1;
        end
        if ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00)) begin
            req_bad = 1'b1;
        end
        if ({2'b00, req_addr[31:2]} >= DEPTH_WORDS) begin
            req_bad = 1'b1;
        end
    end

    // Pick the addressed lane out of the returned word and extend it for loads.
    always_comb begin
        lane_byte  = mem_read_data[7:0];
        case (lat_lane)
            2'd0:    lane_byte = mem_read_data[7:0];
            2'd1:    lane_byte = mem_read_data[15:8];
            2'd2:    lane_byte = mem_read_data[23:16];
            default: lane_byte = mem_read_data[31:24];
        endcase
        lane_half  = lat_lane[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        load_value = mem_read_data;
        case (lat_size)
            SIZE_BYTE: load_value = lat_unsigned ? {24'h000000, lane_byte}
                                                 : {{24{lane_byte[7]}}, lane_byte};
            SIZE_HALF: load_value = lat_unsigned ? {16'h0000, lane_half}
                                                 : {{16{lane_half[15]}}, lane_half};
            default:   load_value = mem_read_data;
        endcase
    end

    // Splice the store data into the addressed lane of the word just read,
    // leaving every other byte exactly as memory returned it.
    always_comb begin
        merged_word = mem_read_data;
        if (lat_size == SIZE_BYTE) begin
            case (lat_lane)
                2'd0:    merged_word[7:0]   = lat_wdata[7:0];
                2'd1:    merged_word[15:8]  = lat_wdata[7:0];
                2'd2:    merged_word[23:16] = lat_wdata[7:0];
                default: merged_word[31:24] = lat_wdata[7:0];
            endcase
        end else if (lat_lane[1]) begin
            merged_word[31:16] = lat_wdata;
        end else begin
            merged_word[15:0]  = lat_wdata;
        end
    end

    // Transaction sequencer: every output it drives is a register that is
    // loaded on the transition into the state where it must be seen.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            ready_reg      <= 1'b1;
            rd_strobe      <= 1'b0;
            wr_strobe      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_error     <= 1'b0;
            resp_rdata     <= 32'h0000_0000;
            mem_address    <= 32'h0000_0000;
            mem_write_data <= 32'h0000_0000;
            lat_write      <= 1'b0;
            lat_size       <= SIZE_BYTE;
            lat_unsigned   <= 1'b0;
            lat_lane       <= 2'b00;
            lat_wdata      <= 16'h0000;
        end else begin
            rd_strobe  <= 1'b0;
            wr_strobe  <= 1'b0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_accept) begin
                        ready_reg    <= 1'b0;
                        lat_write    <= req_write;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_lane     <= req_addr[1:0];
                        lat_wdata    <= req_wdata[15:0];
                        mem_address  <= {2'b00, req_addr[31:2]};
                        resp_rdata   <= 32'h0000_0000;
                        if (req_bad) begin
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            state      <= S_RESP;
                        end else if (req_write && (req_size == SIZE_WORD)) begin
                            mem_write_data <= req_wdata;
                            wr_strobe      <= 1'b1;
                            state          <= S_WRITE;
                        end else begin
                            rd_strobe <= 1'b1;
                            state     <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (lat_write) begin
                        mem_write_data <= merged_word;
                        wr_strobe      <= 1'b1;
                        state          <= S_WRITE;
                    end else begin
                        resp_rdata <= load_value;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    ready_reg <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    ready_reg <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
